// File: rtl/collector_rr_arbiter_if.sv
// Upstream requester bundle plus downstream collector handshake shared by the
// round-robin arbiter (master) and whatever drives the requesters/collector (slave).
interface collector_rr_arbiter_if #(
  parameter int N_PORTS      = 4,
  parameter int PACKET_WIDTH = 56
);
  logic [N_PORTS-1:0]              in_req;
  logic [N_PORTS*PACKET_WIDTH-1:0] in_packet;
  logic [N_PORTS-1:0]              in_gnt;
  logic                            ds_req;
  logic [PACKET_WIDTH-1:0]         ds_packet;
  logic                            ds_gnt;
  logic                            ds_full;

  modport master (
    input  in_req, in_packet, ds_gnt, ds_full,
    output in_gnt, ds_req, ds_packet
  );

  modport slave (
    output in_req, in_packet, ds_gnt, ds_full,
    input  in_gnt, ds_req, ds_packet
  );
endinterface

// File: rtl/collector_rr_arbiter.sv
// Round-robin arbiter sharing one collector port among N_PORTS requesters; latches the
// winner's packet, replays it on the collector Req/Gnt handshake and returns a grant pulse.
module collector_rr_arbiter #(
  parameter int         N_PORTS      = 4,
  parameter int         PACKET_WIDTH = 56,
  parameter int         TIMEOUT      = 255,
  parameter logic [8:0] DONE_CODE    = 9'h167
) (
  input  logic                   clk,
  input  logic                   reset,
  collector_rr_arbiter_if.master bus,
  output logic [15:0]            pkt_count_o,
  output logic [5:0]             last_sender_o,
  output logic                   done_seen_o,
  output logic                   timeout_err_o,
  output logic                   busy_o
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, ACK, GAP} state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [PTR_W-1:0]          cur_q, cur_d;
  logic [15:0]               tmo_q, tmo_d;
  logic                      ds_req_q, ds_req_d;
  logic [PACKET_WIDTH-1:0]   ds_packet_q, ds_packet_d;
  logic [N_PORTS-1:0]        in_gnt_q, in_gnt_d;
  logic [15:0]               pkt_count_q, pkt_count_d;
  logic [5:0]                last_sender_q, last_sender_d;
  logic                      done_seen_q, done_seen_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      busy_q, busy_d;

  logic [PACKET_WIDTH-1:0]   pkt_arr [N_PORTS];
  logic [PTR_W-1:0]          rot_idx [N_PORTS];
  logic [N_PORTS-1:0]        rot_req;
  logic [PTR_W-1:0]          win_idx;

  // rot_req[k] is the request of port (ptr+k) mod N_PORTS, so the lowest set bit wins.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic [PTR_W:0] sum;
    assign pkt_arr[gi] = bus.in_packet[gi*PACKET_WIDTH +: PACKET_WIDTH];
    assign sum         = {1'b0, ptr_q} + (PTR_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (PTR_W+1)'(N_PORTS)) ? PTR_W'(sum - (PTR_W+1)'(N_PORTS))
                                                      : sum[PTR_W-1:0];
    assign rot_req[gi] = bus.in_req[rot_idx[gi]];
  end

  always_comb begin
    win_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (rot_req[k]) win_idx = rot_idx[k];
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_d         = cur_q;
    tmo_d         = tmo_q;
    ds_req_d      = ds_req_q;
    ds_packet_d   = ds_packet_q;
    in_gnt_d      = '0;
    pkt_count_d   = pkt_count_q;
    last_sender_d = last_sender_q;
    done_seen_d   = done_seen_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if ((|bus.in_req) && !bus.ds_full) begin
          ds_packet_d = pkt_arr[win_idx];
          cur_d       = win_idx;
          ds_req_d    = 1'b1;
          tmo_d       = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        tmo_d = tmo_q + 16'd1;
        // A grant in the same cycle as the timeout still completes the transfer.
        if (bus.ds_gnt) begin
          ds_req_d        = 1'b0;
          in_gnt_d[cur_q] = 1'b1;
          ptr_d           = (cur_q == PTR_W'(N_PORTS - 1)) ? '0 : cur_q + 1'b1;
          pkt_count_d     = pkt_count_q + 16'd1;
          last_sender_d   = ds_packet_q[14:9];
          done_seen_d     = done_seen_q | (ds_packet_q[8:0] == DONE_CODE);
          state_d         = ACK;
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          ds_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = GAP;
        end
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cur_q         <= '0;
      tmo_q         <= '0;
      ds_req_q      <= 1'b0;
      ds_packet_q   <= '0;
      in_gnt_q      <= '0;
      pkt_count_q   <= '0;
      last_sender_q <= '0;
      done_seen_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_q         <= cur_d;
      tmo_q         <= tmo_d;
      ds_req_q      <= ds_req_d;
      ds_packet_q   <= ds_packet_d;
      in_gnt_q      <= in_gnt_d;
      pkt_count_q   <= pkt_count_d;
      last_sender_q <= last_sender_d;
      done_seen_q   <= done_seen_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_gnt    = in_gnt_q;
  assign bus.ds_req    = ds_req_q;
  assign bus.ds_packet = ds_packet_q;
  assign pkt_count_o   = pkt_count_q;
  assign last_sender_o = last_sender_q;
  assign done_seen_o   = done_seen_q;
  assign timeout_err_o = timeout_err_q;
  assign busy_o        = busy_q;

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(in_gnt_q));
  a_gnt_needs_ds_gnt: assert property (@(posedge clk) disable iff (!reset)
    (|in_gnt_d) |-> bus.ds_gnt);
`endif

endmodule

// File: tb/tb_collector_rr_arbiter.sv
// Scoreboard bench for collector_rr_arbiter: expected grants are queued as requests are
// raised and popped as grant pulses appear; a small collector model answers ds_req.
module tb_collector_rr_arbiter;

  localparam int NP = 4;
  localparam int PW = 56;

  typedef struct packed {
    logic [1:0]    port;
    logic [PW-1:0] pkt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] pkt_count;
  logic [5:0]  last_sender;
  logic        done_seen;
  logic        timeout_err;
  logic        busy;

  collector_rr_arbiter_if #(.N_PORTS(NP), .PACKET_WIDTH(PW)) intf ();

  collector_rr_arbiter #(
    .N_PORTS(NP), .PACKET_WIDTH(PW), .TIMEOUT(8), .DONE_CODE(9'h167)
  ) dut (
    .clk(clk), .reset(reset), .bus(intf),
    .pkt_count_o(pkt_count), .last_sender_o(last_sender), .done_seen_o(done_seen),
    .timeout_err_o(timeout_err), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt_model;
  exp_t        sb[$];
  bit          col_en;

  // Collector: grants one cycle after it first sees ds_req, drops the grant after one cycle.
  initial begin
    int seen;
    seen = 0;
    intf.ds_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (col_en && intf.ds_req && !intf.ds_gnt) begin
        if (seen >= 1) intf.ds_gnt = 1'b1;
        else seen++;
      end else begin
        intf.ds_gnt = 1'b0;
        seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] make_pkt(input logic [5:0] sid, input logic [8:0] data);
    logic [PW-1:0] p;
    p = PW'({$urandom(), $urandom()});
    p[14:9] = sid;
    p[8:0]  = data;
    return p;
  endfunction

  task automatic set_pkt(input int port, input logic [PW-1:0] p);
    intf.in_packet[port*PW +: PW] = p;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    intf.in_req = '0;
    intf.ds_full = 1'b0;
    col_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt_model = '0;
    sb.delete();
  endtask

  // Bounded wait for a grant pulse; the served requester drops its req on seeing it.
  task automatic wait_gnt(output logic [NP-1:0] g);
    g = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (|intf.in_gnt) begin
        g = intf.in_gnt;
        intf.in_req = intf.in_req & ~g;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    col_en = 1'b0;
    intf.in_req = '0;
    intf.in_packet = '0;
    intf.ds_full = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({intf.ds_req, intf.in_gnt, busy, timeout_err, done_seen} !== 8'b0) begin
      bad++;
      $display("FAIL reset_ctrl: req/gnt/busy/tmo/done=%b want 0",
               {intf.ds_req, intf.in_gnt, busy, timeout_err, done_seen});
    end
    total++;
    if (pkt_count !== 16'd0 || last_sender !== 6'd0 || intf.ds_packet !== '0) begin
      bad++;
      $display("FAIL reset_data: count=%0d sender=%0d pkt=%h want 0", pkt_count, last_sender,
               intf.ds_packet);
    end
    reset = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    logic [PW-1:0] p, pseen;
    logic [NP-1:0] gseen;
    logic [15:0]   cseen;
    logic [5:0]    sseen;
    int            nreq, nbusy, ngnt;
    exp_t          e;
    apply_reset();
    for (int i = 0; i < NP; i++) set_pkt(i, make_pkt(6'(i), 9'(i)));
    p = make_pkt(6'h2A, 9'h005);
    set_pkt(2, p);
    sb.push_back(exp_t'{port: 2'd2, pkt: p});
    nreq = 0; nbusy = 0; ngnt = 0; gseen = '0; pseen = '0; cseen = '0; sseen = '0;
    intf.in_req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (intf.ds_req) nreq++;
      if (busy) nbusy++;
      if (|intf.in_gnt) begin
        ngnt++;
        gseen = intf.in_gnt; pseen = intf.ds_packet; cseen = pkt_count; sseen = last_sender;
        intf.in_req = intf.in_req & ~intf.in_gnt;
      end
    end
    e = sb.pop_front();
    cnt_model++;
    total++;
    if (nreq != 2 || nbusy != 4 || ngnt != 1) begin
      bad++;
      $display("FAIL single_timing: req=%0d busy=%0d gnt=%0d cycles want 2/4/1", nreq, nbusy, ngnt);
    end
    total++;
    if (gseen !== (4'b0001 << e.port) || pseen !== e.pkt) begin
      bad++;
      $display("FAIL single_gnt: gnt=%b pkt=%h want %b %h", gseen, pseen, 4'b0001 << e.port, e.pkt);
    end
    total++;
    if (cseen !== cnt_model || sseen !== e.pkt[14:9]) begin
      bad++;
      $display("FAIL single_stat: count=%0d sender=%h want %0d %h", cseen, sseen, cnt_model,
               e.pkt[14:9]);
    end
    $display("single: port=%0d req_cycles=%0d busy_cycles=%0d", e.port, nreq, nbusy);
  endtask

  task automatic test_fairness();
    logic [NP-1:0] g;
    logic [PW-1:0] p;
    exp_t          e;
    apply_reset();
    for (int i = 0; i < NP; i++) set_pkt(i, make_pkt(6'(8 + i), 9'(16 + i)));
    for (int i = 0; i < NP; i++) sb.push_back(exp_t'{port: 2'(i), pkt: intf.in_packet[i*PW +: PW]});
    intf.in_req = 4'b1111;
    for (int i = 0; i < NP; i++) begin
      wait_gnt(g);
      e = sb.pop_front();
      cnt_model++;
      total++;
      if (g !== (4'b0001 << e.port) || intf.ds_packet !== e.pkt || pkt_count !== cnt_model) begin
        bad++;
        $display("FAIL fair_round1: gnt=%b count=%0d want %b %0d", g, pkt_count,
                 4'b0001 << e.port, cnt_model);
      end
      $display("fair1: grant=%b count=%0d", g, pkt_count);
    end
    p = make_pkt(6'h31, 9'h020);
    set_pkt(1, p);
    sb.push_back(exp_t'{port: 2'd1, pkt: p});
    intf.in_req = 4'b0010;
    wait_gnt(g);
    e = sb.pop_front();
    cnt_model++;
    total++;
    if (g !== 4'b0010 || intf.ds_packet !== e.pkt) begin
      bad++;
      $display("FAIL fair_port1: gnt=%b want 0010", g);
    end
    for (int i = 0; i < NP; i++) begin
      sb.push_back(exp_t'{port: 2'((i + 2) % NP), pkt: intf.in_packet[((i + 2) % NP)*PW +: PW]});
    end
    intf.in_req = 4'b1111;
    for (int i = 0; i < NP; i++) begin
      wait_gnt(g);
      e = sb.pop_front();
      cnt_model++;
      total++;
      if (g !== (4'b0001 << e.port) || intf.ds_packet !== e.pkt || pkt_count !== cnt_model) begin
        bad++;
        $display("FAIL fair_round2: gnt=%b count=%0d want %b %0d", g, pkt_count,
                 4'b0001 << e.port, cnt_model);
      end
      $display("fair2: grant=%b count=%0d", g, pkt_count);
    end
  endtask

  task automatic test_backpressure();
    logic [NP-1:0] g;
    logic [PW-1:0] p;
    exp_t          e;
    int            n;
    p = make_pkt(6'h05, 9'h0AA);
    set_pkt(0, p);
    sb.push_back(exp_t'{port: 2'd0, pkt: p});
    intf.ds_full = 1'b1;
    intf.in_req = 4'b0001;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (intf.ds_req) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL bp_hold: ds_req high %0d cycles want 0", n);
    end
    intf.ds_full = 1'b0;
    @(negedge clk);
    total++;
    if (intf.ds_req !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: ds_req=%b want 1", intf.ds_req);
    end
    wait_gnt(g);
    e = sb.pop_front();
    cnt_model++;
    total++;
    if (g !== 4'b0001 || intf.ds_packet !== e.pkt || pkt_count !== cnt_model) begin
      bad++;
      $display("FAIL bp_gnt: gnt=%b count=%0d want 0001 %0d", g, pkt_count, cnt_model);
    end
    $display("backpressure: held=%0d grant=%b", n, g);
  endtask

  task automatic test_timeout();
    logic [NP-1:0] g;
    logic [PW-1:0] p;
    exp_t          e;
    int            nreq, nerr, ngnt;
    p = make_pkt(6'h11, 9'h001);
    set_pkt(1, p);
    sb.push_back(exp_t'{port: 2'd1, pkt: p});
    intf.in_req = 4'b0010;
    wait_gnt(g);
    e = sb.pop_front();
    cnt_model++;
    total++;
    if (g !== 4'b0010 || intf.ds_packet !== e.pkt) begin
      bad++;
      $display("FAIL tmo_setup: gnt=%b want 0010", g);
    end
    set_pkt(2, make_pkt(6'h12, 9'h002));
    set_pkt(3, make_pkt(6'h13, 9'h003));
    col_en = 1'b0;
    intf.in_req = 4'b1100;
    nreq = 0; nerr = 0; ngnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (intf.ds_req) nreq++;
      if (|intf.in_gnt) ngnt++;
      if (timeout_err) begin
        nerr++;
        intf.in_req = '0;
      end
    end
    total++;
    if (nreq != 8 || nerr != 1 || ngnt != 0) begin
      bad++;
      $display("FAIL tmo_abort: req=%0d err=%0d gnt=%0d cycles want 8/1/0", nreq, nerr, ngnt);
    end
    total++;
    if (pkt_count !== cnt_model) begin
      bad++;
      $display("FAIL tmo_count: count=%0d want %0d", pkt_count, cnt_model);
    end
    col_en = 1'b1;
    sb.push_back(exp_t'{port: 2'd2, pkt: intf.in_packet[2*PW +: PW]});
    sb.push_back(exp_t'{port: 2'd3, pkt: intf.in_packet[3*PW +: PW]});
    intf.in_req = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      wait_gnt(g);
      e = sb.pop_front();
      cnt_model++;
      total++;
      if (g !== (4'b0001 << e.port) || intf.ds_packet !== e.pkt) begin
        bad++;
        $display("FAIL tmo_retry: gnt=%b want %b", g, 4'b0001 << e.port);
      end
      $display("timeout retry: grant=%b", g);
    end
  endtask

  task automatic test_done();
    logic [NP-1:0] g;
    logic [PW-1:0] p;
    logic [8:0]    dat [5];
    logic          want_done;
    exp_t          e;
    dat[0] = 9'h166;
    dat[1] = 9'h167;
    for (int i = 2; i < 5; i++) dat[i] = 9'($urandom_range(0, 9'h166));
    for (int i = 0; i < 5; i++) begin
      p = make_pkt(6'(20 + i), dat[i]);
      set_pkt(i % NP, p);
      sb.push_back(exp_t'{port: 2'(i % NP), pkt: p});
      intf.in_req = 4'b0001 << (i % NP);
      wait_gnt(g);
      e = sb.pop_front();
      cnt_model++;
      want_done = (i != 0);
      total++;
      if (g !== (4'b0001 << e.port) || last_sender !== e.pkt[14:9] || done_seen !== want_done) begin
        bad++;
        $display("FAIL done_flag: gnt=%b sender=%h done=%b want %b %h %b", g, last_sender,
                 done_seen, 4'b0001 << e.port, e.pkt[14:9], want_done);
      end
      $display("done: data=%h done_seen=%b", dat[i], done_seen);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [NP-1:0] g;
    exp_t          e;
    set_pkt(3, make_pkt(6'h33, 9'h033));
    col_en = 1'b0;
    intf.in_req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (intf.ds_req) break;
    end
    total++;
    if (intf.ds_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: ds_req=%b want 1", intf.ds_req);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({intf.ds_req, intf.in_gnt, busy} !== 6'b0 || pkt_count !== 16'd0 || done_seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: req/gnt/busy=%b count=%0d done=%b want 0",
               {intf.ds_req, intf.in_gnt, busy}, pkt_count, done_seen);
    end
    @(negedge clk);
    reset = 1'b1;
    col_en = 1'b1;
    cnt_model = '0;
    sb.delete();
    for (int i = 0; i < NP; i++) set_pkt(i, make_pkt(6'(40 + i), 9'(40 + i)));
    for (int i = 0; i < NP; i++) sb.push_back(exp_t'{port: 2'(i), pkt: intf.in_packet[i*PW +: PW]});
    intf.in_req = 4'b1111;
    for (int i = 0; i < NP; i++) begin
      wait_gnt(g);
      e = sb.pop_front();
      cnt_model++;
      total++;
      if (g !== (4'b0001 << e.port) || pkt_count !== cnt_model) begin
        bad++;
        $display("FAIL rst_order: gnt=%b count=%0d want %b %0d", g, pkt_count,
                 4'b0001 << e.port, cnt_model);
      end
      $display("post-reset: grant=%b count=%0d", g, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_done();
    test_reset_mid_send();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
